block_copy_engine: RTL and testbench
====================================

BLOCK_COPY_ENGINE -- requirements
Module: block_copy_engine

Interface
REQ-001 Parameter ADDR_W, default 16, SRAM word-address width.
REQ-002 Parameter DATA_W, default 32, SRAM word width.
REQ-003 Parameter LEN_W, default 11, transfer-length width; up to 1024 words.
REQ-004 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-005 Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request a copy; sampled in IDLE only.
REQ-007 abort  input  1  cancel a copy in progress; sampled in READ/WRITE only.
REQ-008 srcAddr  input  ADDR_W  first source word address.
REQ-009 dstAddr  input  ADDR_W  first destination word address.
REQ-010 length  input  LEN_W  number of words to copy.
REQ-011 busy  output  1  high while in READ or WRITE.
REQ-012 done  output  1  one-cycle pulse on completion.
REQ-013 wordCount  output  LEN_W  words written so far in the current or last transfer.
REQ-014 address  output  ADDR_W  SRAM address.
REQ-015 inputData  output  DATA_W  SRAM write data.
REQ-016 outputData  input  DATA_W  SRAM read data; combinational from address.
REQ-017 writeEnable  output  1  SRAM write strobe; SRAM writes at the posedge where it is high.

Function
REQ-018 FSM states SHALL be IDLE, READ, WRITE and DONE; the SRAM port SHALL carry at most one access per cycle.
REQ-019 IDLE with start=1 SHALL latch srcAddr, dstAddr and length, clear wordCount, and go to READ if length!=0, else to DONE.
REQ-020 READ SHALL drive address=src+wordCount with writeEnable=0, capture outputData into a holding register at the posedge, and go to WRITE.
REQ-021 WRITE SHALL drive address=dst+wordCount, inputData=holding register and writeEnable=1, then increment wordCount at the posedge.
REQ-022 WRITE SHALL go to DONE when the incremented wordCount equals the latched length, else to READ.
REQ-023 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-024 An N-word copy (N>0) SHALL take 2N+1 cycles from the start edge to the done cycle inclusive; length=0 SHALL produce done on the cycle after the start edge with no SRAM write.
REQ-025 Address sums SHALL be computed modulo 2^ADDR_W, so src/dst regions wrap past the top address.
REQ-026 Words SHALL be copied in ascending order, so overlapping regions follow sequential read-then-write semantics per word.
REQ-027 start SHALL be ignored in READ, WRITE and DONE, and inputs latched in REQ-019 SHALL not change mid-transfer.
REQ-028 abort=1 in READ SHALL go to IDLE with no write; abort=1 in WRITE SHALL complete that cycle's write, increment wordCount, then go to IDLE; an aborted transfer SHALL never pulse done.
REQ-029 Outside WRITE, writeEnable SHALL be 0 and inputData SHALL be 0; in IDLE and DONE, address SHALL be 0.
REQ-030 wordCount SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-031 Rst_n=0 SHALL immediately force state IDLE and set busy=0, done=0, wordCount=0, address=0, inputData=0, writeEnable=0 and the holding register to 0.
REQ-032 Reset asserted mid-transfer SHALL suppress any further write immediately, with no done pulse.
REQ-033 After reset release, the first start SHALL be accepted at the first posedge.

Verification
REQ-034 Preload sram[0..3]=A,B,C,D; start with src=0, dst=16, len=4 -> sram[16..19]=A,B,C,D, done on cycle 9, busy high on cycles 1-8, wordCount=4.
REQ-035 start with len=0 -> done on cycle 1, writeEnable never high, wordCount=0.
REQ-036 src=0xFFFE, dst=0x0010, len=3 -> reads from 0xFFFE, 0xFFFF, 0x0000 in order, written to 0x10-0x12.
REQ-037 len=4, abort asserted in the second WRITE cycle -> exactly two writes occur, wordCount=2, no done, then IDLE.
REQ-038 Rst_n pulsed low during a READ of a len=8 copy -> writeEnable=0 asynchronously, no done, and a new start is accepted afterwards.
REQ-039 Overlap case, src=0, dst=1, len=3 with sram[0]=X -> sram[1..3]=X, X, X.

Source files
------------

// File: rtl/block_copy_engine.sv
// Single-port SRAM block copier: one word read then one word written per two cycles,
// ascending addresses, with abort and a one-cycle done pulse.
module block_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  wordCount,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] inputData,
  input  logic [DATA_W-1:0] outputData,
  output logic              writeEnable,
  output logic [1:0]        dbg_state
);

  // Handshake: start is taken only in IDLE; the transfer ends either with a single-cycle
  // done pulse (normal completion) or silently back in IDLE (abort or reset).
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    wc_q, wc_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    wc_d    = wc_q;
    hold_d  = hold_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = srcAddr;
          dst_d   = dstAddr;
          len_d   = length;
          wc_d    = '0;
          state_d = (length != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        hold_d  = outputData;
        state_d = abort ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        wc_d = wc_q + LEN_W'(1);
        if (abort)              state_d = S_IDLE;
        else if (wc_d == len_q) state_d = S_DONE;
        else                    state_d = S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Port outputs are registered, so they are derived from the state being entered.
    busy_d  = (state_d == S_READ) || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    we_d    = (state_d == S_WRITE);
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == S_READ) begin
      addr_d = src_d + ADDR_W'(wc_d);
    end else if (state_d == S_WRITE) begin
      addr_d  = dst_d + ADDR_W'(wc_d);
      wdata_d = hold_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      wc_q    <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      wc_q    <= wc_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign wordCount   = wc_q;
  assign address     = addr_q;
  assign inputData   = wdata_q;
  assign writeEnable = we_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_block_copy_engine.sv
// Bench for block_copy_engine: SRAM model, word-level copy reference model with an
// expected-write queue, per-cycle protocol checks and a final report.
module tb_block_copy_engine;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 11;

  logic          Clk;
  logic          Rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] srcAddr;
  logic [AW-1:0] dstAddr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [LW-1:0] wordCount;
  logic [AW-1:0] address;
  logic [DW-1:0] inputData;
  logic [DW-1:0] outputData;
  logic          writeEnable;
  logic [1:0]    dbg_state;

  block_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .start       (start),
    .abort       (abort),
    .srcAddr     (srcAddr),
    .dstAddr     (dstAddr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .wordCount   (wordCount),
    .address     (address),
    .inputData   (inputData),
    .outputData  (outputData),
    .writeEnable (writeEnable),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- SRAM model ----------------
  // Unwritten words read back as a seeded hash of their address.
  logic [DW-1:0] mem [0:65535];
  bit            wr_flag [0:65535];
  logic [31:0]   seed;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  always_comb begin
    outputData = wr_flag[address] ? mem[address] : (({16'h0, address} * 32'h9E3779B1) ^ seed);
  end

  always @(posedge Clk) begin
    if (writeEnable) begin
      mem[address]     <= inputData;
      wr_flag[address] <= 1'b1;
    end else if (bd_we) begin
      mem[bd_addr]     <= bd_data;
      wr_flag[bd_addr] <= 1'b1;
    end
  end

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return ({16'h0, a} * 32'h9E3779B1) ^ seed;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return wr_flag[a] ? mem[a] : pattern(a);
  endfunction

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0]    ref_mem [int];
  logic [AW+DW-1:0] exp_q [$];
  int               n_checks;
  int               n_errors;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pattern(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Word-by-word ascending copy: each word reads the memory as left by earlier words.
  task automatic model_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int nw);
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [DW-1:0] v;
    for (int i = 0; i < nw; i++) begin
      a = src + AW'(i);
      b = dst + AW'(i);
      v = ref_rd(a);
      ref_mem[int'(b)] = v;
      exp_q.push_back({b, v});
    end
  endtask

  logic [AW+DW-1:0] mon_e;
  always @(negedge Clk) begin
    if (Rst_n && writeEnable) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(address), 64'(mon_e[AW+DW-1:DW]));
        check("wr_data", 64'(inputData), 64'(mon_e[DW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    ref_mem[int'(a)] = d;
    @(negedge Clk);
    bd_we = 1'b0;
  endtask

  // Called at a negedge. abort_w>0 aborts in that WRITE cycle; rst_at>0 pulses reset in that cycle.
  task automatic run_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len,
                          input int abort_w, input int rst_at);
    int nw;
    int last_busy;
    int done_cyc;
    int kmax;
    logic [AW-1:0] ea;
    if (abort_w > 0)     nw = abort_w;
    else if (rst_at > 0) nw = (rst_at - 1) / 2;
    else                 nw = len;
    model_copy(src, dst, nw);
    last_busy = (abort_w > 0) ? 2 * abort_w : 2 * len;
    done_cyc  = (abort_w > 0 || rst_at > 0) ? -1 : 2 * len + 1;
    kmax      = last_busy + 3;

    start   = 1'b1;
    abort   = 1'b0;
    srcAddr = src;
    dstAddr = dst;
    length  = LW'(len);
    for (int k = 1; k <= kmax; k++) begin
      @(negedge Clk);
      start = 1'b0;
      abort = 1'b0;
      check("busy", 64'(busy), 64'(k <= last_busy));
      check("done", 64'(done), 64'(k == done_cyc));
      check("we", 64'(writeEnable), 64'((k % 2 == 0) && (k <= last_busy)));
      if (k <= last_busy && k % 2 == 1) begin
        ea = src + AW'((k - 1) / 2);
        check("rd_addr", 64'(address), 64'(ea));
      end
      if (k > last_busy) begin
        check("idle_addr", 64'(address), 64'd0);
        check("idle_wdata", 64'(inputData), 64'd0);
      end
      if (k == rst_at) begin
        Rst_n = 1'b0;
        #1;
        check("rst_we", 64'(writeEnable), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr", 64'(address), 64'd0);
        check("rst_wc", 64'(wordCount), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        #1;
        Rst_n     = 1'b1;
        last_busy = 0;
      end else if (k <= last_busy || k == done_cyc) begin
        // Noise on start and the request fields while the engine must ignore them.
        start   = 1'($urandom_range(0, 1));
        srcAddr = AW'($urandom);
        dstAddr = AW'($urandom);
        length  = LW'($urandom);
      end
      if (abort_w > 0 && k == 2 * abort_w) abort = 1'b1;
    end

    check("word_count", 64'(wordCount), 64'((rst_at > 0) ? 0 : nw));
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i <= len; i++) begin
      ea = dst + AW'(i);
      check("mem", 64'(mem_rd(ea)), 64'(ref_rd(ea)));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] abcd [0:3];
  logic [DW-1:0] xval;
  int            rl;
  int            raw;

  initial begin
    n_checks = 0;
    n_errors = 0;
    seed     = $urandom;
    Rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    srcAddr  = '0;
    dstAddr  = '0;
    length   = '0;
    bd_we    = 1'b0;
    bd_addr  = '0;
    bd_data  = '0;

    #7;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_wc", 64'(wordCount), 64'd0);
    check("reset_addr", 64'(address), 64'd0);
    check("reset_wdata", 64'(inputData), 64'd0);
    check("reset_we", 64'(writeEnable), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);

    @(negedge Clk);
    Rst_n = 1'b1;
    run_copy(16'h0100, 16'h0200, 2, 0, 0);

    for (int i = 0; i < 4; i++) begin
      abcd[i] = $urandom;
      poke(AW'(i), abcd[i]);
    end
    run_copy(16'h0000, 16'h0010, 4, 0, 0);
    for (int i = 0; i < 4; i++) check("copy4_mem", 64'(mem_rd(AW'(16 + i))), 64'(abcd[i]));

    run_copy(16'h0040, 16'h0050, 0, 0, 0);
    run_copy(16'hFFFE, 16'h0010, 3, 0, 0);
    run_copy(16'h0300, 16'h0400, 4, 2, 0);
    run_copy(16'h0500, 16'h0600, 8, 0, 3);

    xval = $urandom;
    poke(16'h0000, xval);
    run_copy(16'h0000, 16'h0001, 3, 0, 0);
    for (int i = 1; i <= 3; i++) check("overlap_mem", 64'(mem_rd(AW'(i))), 64'(xval));

    for (int t = 0; t < 10; t++) begin
      rl  = $urandom_range(1, 24);
      raw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rl) : 0;
      run_copy(AW'($urandom), AW'($urandom), rl, raw, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
